// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch controller
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
    typedef enum logic [1:0] {FC_NONE = 2'd0, FC_MISALIGN = 2'd1, FC_RANGE = 2'd2} fault_code_t;
    localparam logic [31:0] SENTINEL    = 32'hFFFF_FFFF;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory bus plus the valid/ready fetch output toward decode
interface fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_last;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    modport master (output imem_addr, if_valid, if_instr, if_pc, input imem_instr, imem_last, if_ready);
    modport slave  (input imem_addr, if_valid, if_instr, if_pc, output imem_instr, imem_last, if_ready);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with one-entry registered fetch output, redirect, stall, halt and fault
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    fetch_ctrl_if.master bus,
    output logic         halted,
    output logic         fault,
    output logic [1:0]   fault_code,
    output logic [15:0]  fetch_count
);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES) - INSTR_BYTES;
    state_t      r_state, w_state_n;
    fault_code_t r_code, w_code_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_if_instr, w_if_instr_n;
    logic [31:0] r_if_pc, w_if_pc_n;
    logic        r_if_valid, w_if_valid_n;
    logic [15:0] r_count, w_count_n;
    logic        w_xfer, w_in_range, w_sentinel, w_capture;

    assign w_xfer     = r_if_valid && bus.if_ready;
    assign w_in_range = r_pc <= LAST_PC;
    assign w_sentinel = (bus.imem_instr == SENTINEL) || bus.imem_last;
    assign w_capture  = (r_state == RUN) && !redirect_valid && !stall && (!r_if_valid || bus.if_ready)
                        && w_in_range && !w_sentinel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_code     <= FC_NONE;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_code     <= w_code_n;
            r_pc       <= w_pc_n;
            r_if_valid <= w_if_valid_n;
            r_if_instr <= w_if_instr_n;
            r_if_pc    <= w_if_pc_n;
            r_count    <= w_count_n;
        end
    end

    // a transfer empties the entry unless a capture refills it in the same cycle
    always_comb begin
        w_state_n    = r_state;
        w_code_n     = r_code;
        w_pc_n       = r_pc;
        w_if_valid_n = r_if_valid && !w_xfer;
        w_if_instr_n = r_if_instr;
        w_if_pc_n    = r_if_pc;
        w_count_n    = r_count;
        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_state_n = FAULT;
                        w_code_n  = FC_MISALIGN;
                    end else begin
                        w_pc_n       = redirect_pc;
                        w_if_valid_n = 1'b0;
                    end
                end else if (!stall) begin
                    if (!w_in_range) begin
                        w_state_n = FAULT;
                        w_code_n  = FC_RANGE;
                    end else if (w_sentinel) begin
                        w_state_n = HALT;
                    end else if (w_capture) begin
                        w_if_instr_n = bus.imem_instr;
                        w_if_pc_n    = r_pc;
                        w_if_valid_n = 1'b1;
                        w_pc_n       = r_pc + INSTR_BYTES;
                        w_count_n    = r_count + 16'd1;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_n    = RUN;
                    w_pc_n       = RESET_PC;
                    w_if_valid_n = 1'b0;
                    w_code_n     = FC_NONE;
                    w_count_n    = '0;
                end
            end
        endcase
    end

    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign halted        = r_state == HALT;
    assign fault         = r_state == FAULT;
    assign fault_code    = r_code;
    assign fetch_count   = r_count;
endmodule
